// File: rtl/fifo_param.sv
// fifo_param -- parametrised single-clock synchronous FIFO.
//
// Buffers WIDTH-bit words between a producer and a consumer in the same clock
// domain. Storage is a DEPTH-entry register array addressed by wrapping write
// and read pointers. Occupancy lives in a dedicated count register, and every
// status flag is decoded from that count.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   wr_en         write request
//   wr_data       write data (WIDTH bits)
//   rd_en         read request
//   rd_data       registered read data; holds its value when no read occurs
//   rd_valid      high for one cycle when rd_data holds a newly popped word
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..DEPTH ($clog2(DEPTH)+1 bits)
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
module fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Elaboration-time parameter checks.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("fifo_param: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_param: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // A read is never accepted on an empty FIFO, even with a simultaneous
  // write, because there is no bypass path. A write into a full FIFO is
  // accepted when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // The flags are decoded from the registered count, so they describe the
  // state after the most recent edge.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // The storage array is deliberately left out of reset. Reset empties the
  // FIFO through the pointers and count instead.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // The pointers wrap naturally from DEPTH-1 to 0 because DEPTH is a power
  // of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy. A write and a read in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Read port: one-cycle latency, and rd_data holds between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
    end
  end

  // Non-sticky error pulses for requests that were rejected.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & ~rd_acc;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed testbench for fifo_param with WIDTH=8 and DEPTH=8.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int passed = 0;
  int total  = 0;

  fifo_param #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Apply one cycle of requests, then sample 1 time unit after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cycle(1'b0, 8'h00, 1'b0); rst = 1'b0;
    total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
    total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", almost_empty); else passed++;
    total++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", almost_full); else passed++;
    total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h exp 00", rd_data); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else passed++;
    total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {overflow, underflow}); else passed++;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      total++; if (count !== 4'(i)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); else passed++;
      total++; if (almost_full !== (i >= 6)) $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i >= 6)); else passed++;
      total++; if (almost_empty !== (i <= 2)) $display("FAIL fill_ae[%0d] got %b exp %b", i, almost_empty, (i <= 2)); else passed++;
      total++; if (full !== (i == 8)) $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 8)); else passed++;
    end
    // A ninth write must be rejected.
    cycle(1'b1, 8'h09, 1'b0);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %b exp 1", overflow); else passed++;
    total++; if (count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", count); else passed++;
    cycle(1'b0, 8'h00, 1'b0);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else passed++;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      total++; if (rd_data !== 8'(i)) $display("FAIL drain_data[%0d] got %h exp %h", i, rd_data, 8'(i)); else passed++;
      total++; if (rd_valid !== 1'b1) $display("FAIL drain_valid[%0d] got %b exp 1", i, rd_valid); else passed++;
      total++; if (count !== 4'(8 - i)) $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 8 - i); else passed++;
    end
    cycle(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL drain_valid_drop got %b exp 0", rd_valid); else passed++;
  endtask

  task automatic test_underflow;
    cycle(1'b0, 8'h00, 1'b1);
    total++; if (underflow !== 1'b1) $display("FAIL udf_pulse got %b exp 1", underflow); else passed++;
    total++; if (rd_data !== 8'h08) $display("FAIL udf_rd_data got %h exp 08", rd_data); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL udf_rd_valid got %b exp 0", rd_valid); else passed++;
    cycle(1'b0, 8'h00, 1'b0);
    total++; if (underflow !== 1'b0) $display("FAIL udf_clear got %b exp 0", underflow); else passed++;
  endtask

  task automatic test_simultaneous;
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    total++; if (full !== 1'b1) $display("FAIL sim_prefill_full got %b exp 1", full); else passed++;
    // At full, a write paired with a read is accepted.
    cycle(1'b1, 8'h99, 1'b1);
    total++; if (count !== 4'd8) $display("FAIL sim_full_count got %0d exp 8", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL sim_full_ovf got %b exp 0", overflow); else passed++;
    total++; if (rd_data !== 8'h11) $display("FAIL sim_full_data got %h exp 11", rd_data); else passed++;
    total++; if (rd_valid !== 1'b1) $display("FAIL sim_full_valid got %b exp 1", rd_valid); else passed++;
    for (int i = 2; i <= 9; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 9) ? 8'h99 : 8'(8'h10 + i);
      cycle(1'b0, 8'h00, 1'b1);
      total++; if (rd_data !== exp_d) $display("FAIL sim_drain_data[%0d] got %h exp %h", i, rd_data, exp_d); else passed++;
    end
    total++; if (empty !== 1'b1) $display("FAIL sim_drain_empty got %b exp 1", empty); else passed++;
    // When empty, the write is taken but the read is refused.
    cycle(1'b1, 8'h55, 1'b1);
    total++; if (count !== 4'd1) $display("FAIL sim_empty_count got %0d exp 1", count); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL sim_empty_udf got %b exp 1", underflow); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL sim_empty_valid got %b exp 0", rd_valid); else passed++;
    cycle(1'b0, 8'h00, 1'b1);
    total++; if (rd_data !== 8'h55) $display("FAIL sim_empty_data got %h exp 55", rd_data); else passed++;
    total++; if (count !== 4'd0) $display("FAIL sim_empty_final got %0d exp 0", count); else passed++;
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    for (int c = 0; c < 23; c++) begin
      logic       w, r, ra;
      logic [7:0] exp_d;
      w = (c < 20);
      r = (c >= 3);
      ra = r && (q.size() > 0);
      exp_d = 8'h00;
      if (ra) exp_d = q.pop_front();
      if (w && (q.size() < 8 || ra)) q.push_back(8'(8'h40 + c));
      cycle(w, 8'(8'h40 + c), r);
      total++; if (rd_valid !== ra) $display("FAIL wrap_valid[%0d] got %b exp %b", c, rd_valid, ra); else passed++;
      if (ra) begin
        total++; if (rd_data !== exp_d) $display("FAIL wrap_data[%0d] got %h exp %h", c, rd_data, exp_d); else passed++;
      end
      total++; if (count !== 4'(q.size())) $display("FAIL wrap_count[%0d] got %0d exp %0d", c, count, q.size()); else passed++;
      total++; if ({overflow, underflow, full} !== 3'b000) $display("FAIL wrap_flags[%0d] got %b exp 000", c, {overflow, underflow, full}); else passed++;
    end
    total++; if (empty !== 1'b1) $display("FAIL wrap_empty got %b exp 1", empty); else passed++;
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    total++; if (count !== 4'd5) $display("FAIL rmid_pre_count got %0d exp 5", count); else passed++;
    rst = 1'b1; cycle(1'b1, 8'h77, 1'b1); rst = 1'b0;
    total++; if (count !== 4'd0) $display("FAIL rmid_count got %0d exp 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rmid_empty got %b exp 1", empty); else passed++;
    total++; if ({overflow, underflow, rd_valid} !== 3'b000) $display("FAIL rmid_pulses got %b exp 000", {overflow, underflow, rd_valid}); else passed++;
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    total++; if (rd_data !== 8'hAA) $display("FAIL rmid_data got %h exp aa", rd_data); else passed++;
    total++; if (rd_valid !== 1'b1) $display("FAIL rmid_valid got %b exp 1", rd_valid); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rmid_final_empty got %b exp 1", empty); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_fill_drain;
    test_underflow;
    test_simultaneous;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock synchronous FIFO: the next generation of the team's 8x8 FIFO, with configurable data width and depth, occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe and overflow/underflow error pulses. It buffers data between a producer and a consumer in the same clock domain. Typical uses are stream buffering and rate smoothing in front of datapath blocks.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  read data (registered)
- rd_valid  out  1  high for one cycle when rd_data holds a newly popped word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage: DEPTH x WIDTH register array. Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is held in the count register, CW bits wide.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en & !empty. A read on an empty FIFO is never accepted, even with a simultaneous write; no bypass path exists.
- On wr_acc: mem[wr_ptr] <= wr_data, then wr_ptr increments.
- On rd_acc: rd_data <= mem[rd_ptr], then rd_ptr increments.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- When no read is accepted, rd_data holds its last value.
- All flags are decoded from the registered count, so they reflect the state after the most recent edge.
- overflow <= wr_en & !wr_acc; underflow <= rd_en & !rd_acc. Both are registered and non-sticky.
- Reset (rst=1 at an edge) takes priority over every other action in that cycle:
  - wr_ptr, rd_ptr and count go to 0; rd_data goes to 0.
  - rd_valid, overflow and underflow go to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0). AF_THRESH is >=1 by parameter rule, so almost_full=0.
  - Memory contents are not cleared.
  - Requests presented during reset are discarded; reset mid-stream drops all stored data.
- Parameter checks: elaboration fails if DEPTH is not a power of two, or if either threshold is out of range.

## Timing
- Write-to-read latency: a word written at edge N is visible at the next edge. empty falls after edge N, so rd_en in cycle N+1 pops it at edge N+1. rd_data and rd_valid are valid after edge N+1.
- Read latency: 1 cycle. rd_acc is sampled at edge N; rd_data and rd_valid are updated at edge N, and rd_valid drops at edge N+1 unless another read is accepted.
- Flag latency: full, empty, almost_* and count change at the same edge as the pointer update that causes them.
- Error pulses: overflow and underflow are high for exactly the one cycle following the rejected request.
- Throughput: one write and one read per cycle, sustained. At count == DEPTH with both requests active, count stays at DEPTH and no overflow is raised.

## Test plan
- Reset then idle: after rst, expect count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0.
- Fill and drain (WIDTH=8, DEPTH=8): write 0x01..0x08 on consecutive cycles.
  - Expect full=1 after the 8th write, almost_full=1 once count=6, count=8.
  - Then read 8 times: rd_data=0x01..0x08 in order, with rd_valid high each cycle; finally empty=1.
- Overflow and underflow:
  - At full, a 9th write of 0x09 gives overflow=1 for 1 cycle; count stays 8, and 0x09 is never read back.
  - When empty, rd_en gives underflow=1 for 1 cycle; rd_data is unchanged and rd_valid=0.
- Simultaneous access:
  - At count=8, wr_en+rd_en: count stays 8, no overflow, and the new word is read out last.
  - At count=0, wr_en+rd_en: write accepted, read rejected (underflow=1), count=1.
- Wrap-around: 20 interleaved write/read pairs of incrementing data with count oscillating 0..3. Output order must match input order across pointer wrap, with no spurious flags.
- Reset mid-operation: with count=5, assert rst alongside wr_en and rd_en. Expect count=0, empty=1 and no pulses. The next write of 0xAA reads back as 0xAA.
